// File: rtl/ex_flag_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_flag_stage
// Description : Execute-stage back end. Resolves carry/zero conditional
//               execution, owns the architectural C/Z flags, registers the
//               surviving ALU result into the EX/MEM pipeline register under
//               stall/flush control and keeps two wrap-around counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_flag_stage #(
  parameter int WIDTH = 16,
  parameter int RA_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic [1:0]       cond,
  input  logic             c_we,
  input  logic             z_we,
  input  logic [RA_W-1:0]  rd_addr,
  input  logic             rd_we,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic [WIDTH-1:0] store_data,
  input  logic             stall,
  input  logic             flush,
  output logic             c_flag,
  output logic             z_flag,
  output logic             em_valid,
  output logic [WIDTH-1:0] em_result,
  output logic [RA_W-1:0]  em_rd_addr,
  output logic             em_rd_we,
  output logic             em_mem_rd,
  output logic             em_mem_wr,
  output logic [WIDTH-1:0] em_store_data,
  output logic [15:0]      retired_cnt,
  output logic [15:0]      squash_cnt
);

  // Condition field encodings.
  localparam logic [1:0] c_COND_ALWAYS = 2'b00;
  localparam logic [1:0] c_COND_IF_C   = 2'b01;
  localparam logic [1:0] c_COND_IF_Z   = 2'b10;

  localparam logic [15:0] c_CNT_ONE = 16'd1;

  // Architectural flags.
  logic             r_c_flag;
  logic             r_z_flag;

  // EX/MEM pipeline register.
  logic             r_em_valid;
  logic [WIDTH-1:0] r_em_result;
  logic [RA_W-1:0]  r_em_rd_addr;
  logic             r_em_rd_we;
  logic             r_em_mem_rd;
  logic             r_em_mem_wr;
  logic [WIDTH-1:0] r_em_store_data;

  // Performance counters (free-running wrap).
  logic [15:0]      r_retired_cnt;
  logic [15:0]      r_squash_cnt;

  logic             w_cond_met;
  logic             w_z_next;

  // Condition check against the registered flags only, so a flag-producing
  // instruction is seen by its successor without any bypass network.
  always_comb begin
    w_cond_met = (cond == c_COND_ALWAYS)
               | ((cond == c_COND_IF_C) & r_c_flag)
               | ((cond == c_COND_IF_Z) & r_z_flag);
    w_z_next   = (alu_result == '0);
  end

  // Flag, EX/MEM and counter update: flush beats stall beats normal flow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c_flag        <= 1'b0;
      r_z_flag        <= 1'b0;
      r_em_valid      <= 1'b0;
      r_em_result     <= '0;
      r_em_rd_addr    <= '0;
      r_em_rd_we      <= 1'b0;
      r_em_mem_rd     <= 1'b0;
      r_em_mem_wr     <= 1'b0;
      r_em_store_data <= '0;
      r_retired_cnt   <= '0;
      r_squash_cnt    <= '0;
    end else if (flush) begin
      // Squash: drop the EX instruction even if downstream is stalled.
      r_em_valid      <= 1'b0;
      r_em_result     <= '0;
      r_em_rd_addr    <= '0;
      r_em_rd_we      <= 1'b0;
      r_em_mem_rd     <= 1'b0;
      r_em_mem_wr     <= 1'b0;
      r_em_store_data <= '0;
      if (in_valid) begin
        r_squash_cnt <= r_squash_cnt + c_CNT_ONE;
      end
    end else if (!stall) begin
      if (in_valid && w_cond_met) begin
        r_em_valid      <= 1'b1;
        r_em_result     <= alu_result;
        r_em_rd_addr    <= rd_addr;
        r_em_rd_we      <= rd_we;
        r_em_mem_rd     <= mem_rd;
        r_em_mem_wr     <= mem_wr;
        r_em_store_data <= store_data;
        if (c_we) begin
          r_c_flag <= alu_carry;
        end
        if (z_we) begin
          r_z_flag <= w_z_next;
        end
        r_retired_cnt <= r_retired_cnt + c_CNT_ONE;
      end else begin
        // Condition failed or empty slot: pass a bubble downstream.
        r_em_valid      <= 1'b0;
        r_em_result     <= '0;
        r_em_rd_addr    <= '0;
        r_em_rd_we      <= 1'b0;
        r_em_mem_rd     <= 1'b0;
        r_em_mem_wr     <= 1'b0;
        r_em_store_data <= '0;
        if (in_valid) begin
          r_squash_cnt <= r_squash_cnt + c_CNT_ONE;
        end
      end
    end
    // Stall without flush: every register holds its value.
  end

  assign c_flag        = r_c_flag;
  assign z_flag        = r_z_flag;
  assign em_valid      = r_em_valid;
  assign em_result     = r_em_result;
  assign em_rd_addr    = r_em_rd_addr;
  assign em_rd_we      = r_em_rd_we;
  assign em_mem_rd     = r_em_mem_rd;
  assign em_mem_wr     = r_em_mem_wr;
  assign em_store_data = r_em_store_data;
  assign retired_cnt   = r_retired_cnt;
  assign squash_cnt    = r_squash_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ex_flag_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_flag_stage
// Description : Self-checking bench for ex_flag_stage. Directed scenarios plus
//               randomized traffic compared against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_flag_stage;

  localparam int WIDTH = 16;
  localparam int RA_W  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic [1:0]       cond;
  logic             c_we;
  logic             z_we;
  logic [RA_W-1:0]  rd_addr;
  logic             rd_we;
  logic             mem_rd;
  logic             mem_wr;
  logic [WIDTH-1:0] store_data;
  logic             stall;
  logic             flush;
  logic             c_flag;
  logic             z_flag;
  logic             em_valid;
  logic [WIDTH-1:0] em_result;
  logic [RA_W-1:0]  em_rd_addr;
  logic             em_rd_we;
  logic             em_mem_rd;
  logic             em_mem_wr;
  logic [WIDTH-1:0] em_store_data;
  logic [15:0]      retired_cnt;
  logic [15:0]      squash_cnt;

  ex_flag_stage #(.WIDTH(WIDTH), .RA_W(RA_W)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .alu_result    (alu_result),
    .alu_carry     (alu_carry),
    .cond          (cond),
    .c_we          (c_we),
    .z_we          (z_we),
    .rd_addr       (rd_addr),
    .rd_we         (rd_we),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .store_data    (store_data),
    .stall         (stall),
    .flush         (flush),
    .c_flag        (c_flag),
    .z_flag        (z_flag),
    .em_valid      (em_valid),
    .em_result     (em_result),
    .em_rd_addr    (em_rd_addr),
    .em_rd_we      (em_rd_we),
    .em_mem_rd     (em_mem_rd),
    .em_mem_wr     (em_mem_wr),
    .em_store_data (em_store_data),
    .retired_cnt   (retired_cnt),
    .squash_cnt    (squash_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Reference model state: one EX/MEM entry, two flags, two counters.
  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] res;
    logic [RA_W-1:0]  rd;
    logic             we;
    logic             mr;
    logic             mw;
    logic [WIDTH-1:0] sd;
  } em_t;

  em_t         m_em;
  logic        m_c;
  logic        m_z;
  logic [15:0] m_ret;
  logic [15:0] m_sq;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_em  = '0;
    m_c   = 1'b0;
    m_z   = 1'b0;
    m_ret = '0;
    m_sq  = '0;
  endtask

  // One clock edge of architectural behaviour, from the instruction rules.
  task automatic model_edge();
    bit met;
    if (flush) begin
      m_em = '0;
      if (in_valid) m_sq = m_sq + 16'd1;
    end else if (!stall) begin
      case (cond)
        2'b00:   met = 1'b1;
        2'b01:   met = m_c;
        2'b10:   met = m_z;
        default: met = 1'b0;
      endcase
      if (in_valid && met) begin
        m_em = '{1'b1, alu_result, rd_addr, rd_we, mem_rd, mem_wr, store_data};
        if (c_we) m_c = alu_carry;
        if (z_we) m_z = (alu_result == 0);
        m_ret = m_ret + 16'd1;
      end else begin
        m_em = '0;
        if (in_valid) m_sq = m_sq + 16'd1;
      end
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".c_flag"},     32'(c_flag),        32'(m_c));
    chk({ctx, ".z_flag"},     32'(z_flag),        32'(m_z));
    chk({ctx, ".em_valid"},   32'(em_valid),      32'(m_em.v));
    chk({ctx, ".em_result"},  32'(em_result),     32'(m_em.res));
    chk({ctx, ".em_rd_addr"}, 32'(em_rd_addr),    32'(m_em.rd));
    chk({ctx, ".em_rd_we"},   32'(em_rd_we),      32'(m_em.we));
    chk({ctx, ".em_mem_rd"},  32'(em_mem_rd),     32'(m_em.mr));
    chk({ctx, ".em_mem_wr"},  32'(em_mem_wr),     32'(m_em.mw));
    chk({ctx, ".em_store"},   32'(em_store_data), 32'(m_em.sd));
    chk({ctx, ".retired"},    32'(retired_cnt),   32'(m_ret));
    chk({ctx, ".squash"},     32'(squash_cnt),    32'(m_sq));
  endtask

  task automatic set_idle();
    in_valid   = 1'b0;
    alu_result = '0;
    alu_carry  = 1'b0;
    cond       = 2'b00;
    c_we       = 1'b0;
    z_we       = 1'b0;
    rd_addr    = '0;
    rd_we      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    store_data = '0;
    stall      = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic rand_instr();
    in_valid   = 1'($urandom_range(0, 3) != 0);
    alu_result = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
    alu_carry  = 1'($urandom);
    cond       = 2'($urandom);
    c_we       = 1'($urandom);
    z_we       = 1'($urandom);
    rd_addr    = 3'($urandom);
    rd_we      = 1'($urandom);
    mem_rd     = 1'($urandom);
    mem_wr     = 1'($urandom);
    store_data = 16'($urandom);
  endtask

  // Advance one edge; model sees the same inputs the DUT sampled.
  task automatic step(input bit do_chk, input string ctx);
    @(posedge clk);
    model_edge();
    #1;
    if (do_chk) check_all(ctx);
  endtask

  // Asynchronous reset pulse mid-cycle; outputs must clear before any edge.
  task automatic async_reset(input string ctx);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(ctx);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [15:0] snap_ret;
  logic [15:0] snap_sq;

  initial begin
    set_idle();
    rst = 1'b1;
    model_reset();
    #12;
    check_all("reset0");
    rst = 1'b0;

    // Add with carry, zero result.
    in_valid = 1'b1; cond = 2'b00; alu_result = 16'h0000; alu_carry = 1'b1;
    c_we = 1'b1; z_we = 1'b1; rd_addr = 3'd3; rd_we = 1'b1;
    step(1, "addc");
    chk("addc.em_valid_spec", 32'(em_valid), 32'd1);
    chk("addc.rd_spec",       32'(em_rd_addr), 32'd3);
    chk("addc.c_spec",        32'(c_flag), 32'd1);
    chk("addc.z_spec",        32'(z_flag), 32'd1);
    chk("addc.ret_spec",      32'(retired_cnt), 32'd1);

    // Asynchronous reset with em_valid=1 and C=1.
    set_idle();
    async_reset("async_rst");
    chk("async_rst.c_spec", 32'(c_flag), 32'd0);

    // Conditional chain starting from C=0.
    set_idle();
    in_valid = 1'b1; cond = 2'b01; alu_result = 16'h0042; c_we = 1'b1;
    alu_carry = 1'b1;
    step(1, "cchain1");
    chk("cchain1.valid_spec",  32'(em_valid), 32'd0);
    chk("cchain1.squash_spec", 32'(squash_cnt), 32'd1);
    cond = 2'b00; alu_result = 16'h0005; alu_carry = 1'b1; c_we = 1'b1;
    step(1, "cchain2");
    cond = 2'b01; alu_result = 16'h0007; c_we = 1'b0;
    step(1, "cchain3");
    chk("cchain3.valid_spec", 32'(em_valid), 32'd1);

    // Stall hold for three cycles while inputs change.
    set_idle();
    in_valid = 1'b1; cond = 2'b00; alu_result = 16'h1234; rd_we = 1'b1;
    step(1, "stall_load");
    snap_ret = retired_cnt;
    snap_sq  = squash_cnt;
    for (int i = 0; i < 3; i++) begin
      rand_instr();
      stall = 1'b1;
      flush = 1'b0;
      step(1, "stall_hold");
      chk("stall_hold.result_spec", 32'(em_result), 32'h1234);
      chk("stall_hold.valid_spec",  32'(em_valid), 32'd1);
      chk("stall_hold.ret_spec",    32'(retired_cnt), 32'(snap_ret));
      chk("stall_hold.sq_spec",     32'(squash_cnt), 32'(snap_sq));
    end

    // Flush wins over stall and counts the squashed instruction.
    snap_sq = squash_cnt;
    rand_instr();
    in_valid = 1'b1; stall = 1'b1; flush = 1'b1;
    step(1, "flush_stall");
    chk("flush_stall.valid_spec", 32'(em_valid), 32'd0);
    chk("flush_stall.sq_spec",    32'(squash_cnt), 32'(snap_sq + 16'd1));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rand_instr();
      stall = 1'($urandom_range(0, 3) == 0);
      flush = 1'($urandom_range(0, 9) == 0);
      step(1, "rand");
    end

    // Retired counter wrap.
    set_idle();
    async_reset("wrap_rst");
    in_valid = 1'b1; cond = 2'b00; alu_result = 16'h0001;
    for (int i = 0; i < 65535; i++) begin
      step(0, "wrap_fill");
    end
    check_all("wrap_full");
    chk("wrap_full.ret_spec", 32'(retired_cnt), 32'hFFFF);
    step(1, "wrap");
    chk("wrap.ret_spec", 32'(retired_cnt), 32'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
